user_pos_ctrl: RTL and testbench

USER_POS_CTRL -- requirements
Module: user_pos_ctrl

---
 rtl/user_pos_ctrl.sv | 161 ++++++++++++++++
 tb/tb_user_pos_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/user_pos_ctrl.sv
// user_pos_ctrl: moves the user sprite by STEP pixels at most once per frame.
// The move is chosen from the synchronized buttons on the vsync rising edge.
// The target is clamped to the screen and then sent to an external collision
// checker. The move is committed only if the checker answers with no hit.
// A game_won flag locks the position until reset.
//
// Ports:
//   pclk, rst                       pixel clock, synchronous active-high reset
//   vsync_in                        vsync from the timing generator (pclk domain)
//   btn_up/down/left/right          asynchronous active-high buttons
//   game_won                        win flag; forces the frozen WON state
//   chk_ack, chk_hit                checker response valid / overlap flag
//   chk_req, cand_x, cand_y         check request and the candidate position
//   x_pos, y_pos                    committed sprite top-left position
//   frozen                          high once movement is locked
module user_pos_ctrl #(
  parameter int STEP        = 4,
  parameter int WIDTH       = 100,
  parameter int HEIGHT      = 100,
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600,
  parameter int X_START     = 0,
  parameter int Y_START     = 250,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        game_won,
  input  logic        chk_ack,
  input  logic        chk_hit,
  output logic        chk_req,
  output logic [11:0] cand_x,
  output logic [11:0] cand_y,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        frozen
);

  localparam logic [11:0] STP   = 12'(STEP);
  localparam logic [11:0] MAX_X = 12'(SCREEN_W - WIDTH);
  localparam logic [11:0] MAX_Y = 12'(SCREEN_H - HEIGHT);
  localparam int          CW    = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PROPOSE, WAIT_ACK, WON} state_t;

  state_t        state, state_nxt;
  logic [3:0]    btn_s1, btn_s2;   // {up, down, left, right}
  logic          vs_q;
  logic          frame_tick;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [11:0]   x_nxt, y_nxt, cx_nxt, cy_nxt;
  logic [11:0]   mv_x, mv_y;
  logic [12:0]   sum_x, sum_y;

  assign frame_tick = vsync_in & ~vs_q;
  assign chk_req    = (state == PROPOSE) || (state == WAIT_ACK);
  assign frozen     = (state == WON);

  // The sums are one bit wider so that a move past the far edge can be
  // detected without wrapping.
  assign sum_x = {1'b0, x_pos} + {1'b0, STP};
  assign sum_y = {1'b0, y_pos} + {1'b0, STP};

  // Clamped target for the highest-priority pressed button. With no button
  // pressed the target equals the current position, which means no move.
  always_comb begin
    mv_x = x_pos;
    mv_y = y_pos;
    if (btn_s2[3])
      mv_y = (y_pos < STP) ? 12'd0 : y_pos - STP;
    else if (btn_s2[2])
      mv_y = (sum_y > {1'b0, MAX_Y}) ? MAX_Y : sum_y[11:0];
    else if (btn_s2[1])
      mv_x = (x_pos < STP) ? 12'd0 : x_pos - STP;
    else if (btn_s2[0])
      mv_x = (sum_x > {1'b0, MAX_X}) ? MAX_X : sum_x[11:0];
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_pos;
    y_nxt     = y_pos;
    cx_nxt    = cand_x;
    cy_nxt    = cand_y;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cx_nxt  = x_pos;
        cy_nxt  = y_pos;
        cnt_nxt = '0;
        if (frame_tick && (|btn_s2) && ((mv_x != x_pos) || (mv_y != y_pos))) begin
          cx_nxt    = mv_x;
          cy_nxt    = mv_y;
          state_nxt = PROPOSE;
        end
      end
      PROPOSE, WAIT_ACK: begin
        if (chk_ack) begin
          // On a hit the candidate goes back to the current position. On a
          // miss it already equals the new position.
          if (!chk_hit) begin
            x_nxt = cand_x;
            y_nxt = cand_y;
          end else begin
            cx_nxt = x_pos;
            cy_nxt = y_pos;
          end
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          cx_nxt    = x_pos;
          cy_nxt    = y_pos;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WON: ;
      default: state_nxt = IDLE;
    endcase
    // A win overrides everything, including an ack in the same cycle.
    if (game_won) begin
      state_nxt = WON;
      x_nxt     = x_pos;
      y_nxt     = y_pos;
      cx_nxt    = x_pos;
      cy_nxt    = y_pos;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state  <= IDLE;
      btn_s1 <= '0;
      btn_s2 <= '0;
      vs_q   <= 1'b0;
      cnt    <= '0;
      x_pos  <= 12'(X_START);
      y_pos  <= 12'(Y_START);
      cand_x <= 12'(X_START);
      cand_y <= 12'(Y_START);
    end else begin
      btn_s1 <= {btn_up, btn_down, btn_left, btn_right};
      btn_s2 <= btn_s1;
      vs_q   <= vsync_in;
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      x_pos  <= x_nxt;
      y_pos  <= y_nxt;
      cand_x <= cx_nxt;
      cand_y <= cy_nxt;
    end
  end

endmodule

// File: tb/tb_user_pos_ctrl.sv
module tb_user_pos_ctrl;

  logic        pclk = 1'b0;
  logic        rst, vsync_in, btn_up, btn_down, btn_left, btn_right;
  logic        game_won, chk_ack, chk_hit;
  logic        chk_req, frozen;
  logic [11:0] cand_x, cand_y, x_pos, y_pos;

  // Second instance starts at x=698 to reach the right-edge clamp directly.
  logic        game_won2, chk_ack2, chk_hit2;
  logic        chk_req2, frozen2;
  logic [11:0] cand_x2, cand_y2, x_pos2, y_pos2;

  int nvec = 0;
  int nerr = 0;
  int n;

  always #5 pclk = ~pclk;

  user_pos_ctrl u_dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .game_won(game_won), .chk_ack(chk_ack), .chk_hit(chk_hit),
    .chk_req(chk_req), .cand_x(cand_x), .cand_y(cand_y),
    .x_pos(x_pos), .y_pos(y_pos), .frozen(frozen)
  );

  user_pos_ctrl #(.X_START(698)) u_dut2 (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .game_won(game_won2), .chk_ack(chk_ack2), .chk_hit(chk_hit2),
    .chk_req(chk_req2), .cand_x(cand_x2), .cand_y(cand_y2),
    .x_pos(x_pos2), .y_pos(y_pos2), .frozen(frozen2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
  endtask

  // b = {up, down, left, right}. Returns at the first negedge after the
  // frame_tick edge, which is when chk_req first shows.
  task automatic frame(input logic [3:0] b);
    @(negedge pclk);
    {btn_up, btn_down, btn_left, btn_right} = b;
    repeat (3) @(negedge pclk);
    vsync_in = 1'b1;
    @(negedge pclk);
    vsync_in = 1'b0;
  endtask

  task automatic ack(input int dly, input logic hit);
    repeat (dly) @(negedge pclk);
    chk_ack = 1'b1;
    chk_hit = hit;
    @(negedge pclk);
    chk_ack = 1'b0;
    chk_hit = 1'b0;
  endtask

  initial begin
    rst = 1'b0; vsync_in = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    game_won = 1'b0; chk_ack = 1'b0; chk_hit = 1'b0;
    game_won2 = 1'b0; chk_ack2 = 1'b0; chk_hit2 = 1'b0;

    // Reset state
    do_reset();
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 250);
    chk("rst_cand_x", cand_x, 0);
    chk("rst_cand_y", cand_y, 250);
    chk("rst_req", chk_req, 0);
    chk("rst_frozen", frozen, 0);

    // Right-edge clamp on the second instance (698 -> 700 -> stays)
    frame(4'b0001);
    chk("edge_req", chk_req2, 1);
    chk("edge_cand_x", cand_x2, 700);
    chk_ack2 = 1'b1;
    @(negedge pclk);
    chk_ack2 = 1'b0;
    chk("edge_commit", x_pos2, 700);
    repeat (20) @(negedge pclk);
    frame(4'b0001);
    chk("edge_noreq", chk_req2, 0);
    chk("edge_hold", x_pos2, 700);
    repeat (20) @(negedge pclk);
    do_reset();

    // Basic right move, ack after 3 cycles
    frame(4'b0001);
    chk("r_req", chk_req, 1);
    chk("r_cand_x", cand_x, 4);
    chk("r_cand_y", cand_y, 250);
    repeat (3) @(negedge pclk);
    chk("r_req_hold", chk_req, 1);
    chk("r_cand_hold", cand_x, 4);
    chk("r_pos_pend", x_pos, 0);
    ack(0, 1'b0);
    chk("r_x", x_pos, 4);
    chk("r_y", y_pos, 250);
    chk("r_req_drop", chk_req, 0);
    chk("r_cand_eq", cand_x, 4);

    // Stray ack while idle is ignored
    chk_ack = 1'b1; chk_hit = 1'b0;
    @(negedge pclk);
    chk_ack = 1'b0;
    chk("stray_x", x_pos, 4);

    // Left to 0, then left at the edge gives no request
    frame(4'b0010);
    ack(0, 1'b0);
    chk("l_x", x_pos, 0);
    frame(4'b0010);
    chk("l_noreq", chk_req, 0);
    chk("l_hold_x", x_pos, 0);
    chk("l_hold_y", y_pos, 250);

    // Walk right to x=100
    for (int i = 0; i < 25; i++) begin
      frame(4'b0001);
      ack(0, 1'b0);
    end
    chk("walk_x", x_pos, 100);

    // Up beats left; the checker reports a hit
    frame(4'b1010);
    chk("ul_req", chk_req, 1);
    chk("ul_cand_x", cand_x, 100);
    chk("ul_cand_y", cand_y, 246);
    ack(1, 1'b1);
    chk("ul_x", x_pos, 100);
    chk("ul_y", y_pos, 250);
    chk("ul_cand_back", cand_y, 250);
    chk("ul_req_drop", chk_req, 0);

    // Timeout: chk_req high for 16 cycles with no ack
    frame(4'b0001);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!chk_req) break;
      n++;
      @(negedge pclk);
    end
    chk("to_cycles", n, 16);
    chk("to_x", x_pos, 100);
    chk("to_cand_back", cand_x, 100);
    frame(4'b0001);
    chk("to_retry_req", chk_req, 1);
    ack(0, 1'b0);
    chk("to_retry_x", x_pos, 104);

    // Down move
    frame(4'b0100);
    chk("d_cand_y", cand_y, 254);
    ack(2, 1'b0);
    chk("d_y", y_pos, 254);

    // Reset mid-check, then a late ack
    frame(4'b0001);
    chk("rm_req", chk_req, 1);
    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    chk("rm_req_drop", chk_req, 0);
    chk("rm_x", x_pos, 0);
    ack(0, 1'b0);
    chk("rm_late_x", x_pos, 0);
    chk("rm_late_cand", cand_x, 0);

    // game_won with a simultaneous ack: no commit, then frozen
    frame(4'b0001);
    @(negedge pclk);
    game_won = 1'b1; chk_ack = 1'b1; chk_hit = 1'b0;
    @(negedge pclk);
    game_won = 1'b0; chk_ack = 1'b0;
    chk("won_frozen", frozen, 1);
    chk("won_req", chk_req, 0);
    chk("won_x", x_pos, 0);
    frame(4'b0001);
    chk("won_noreq", chk_req, 0);
    ack(0, 1'b0);
    chk("won_hold_x", x_pos, 0);
    chk("won_still", frozen, 1);
    do_reset();
    chk("won_rst", frozen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
